// File: rtl/lcd_write_ctrl_pkg.sv
// Shared types and constants for the HD44780 write controller.
// Optional power-up init sequence: LCD_WRITE_CTRL_INIT_EN.
package lcd_write_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_EXEC
  } state_e;

  localparam int RS_BIT   = 8;
  localparam int BLON_BIT = 30;
  localparam int ON_BIT   = 31;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  localparam int INIT_LEN = 6;

  function automatic logic [7:0] init_cmd(
    input logic [2:0] idx
  );
    logic [7:0] c;
    c = 8'h00;
    case (idx)
      3'd0:    c = 8'h38;
      3'd1:    c = 8'h38;
      3'd2:    c = 8'h38;
      3'd3:    c = 8'h0C;
      3'd4:    c = 8'h01;
      3'd5:    c = 8'h06;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic is_long(
    input logic       rs,
    input logic [7:0] b
  );
    return !rs && (b == OP_CLEAR ||
                   b == OP_HOME  ||
                   b == OP_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_write_ctrl_timer.sv
// Loadable down-counter; holds at zero until reloaded.
// Shared by every timed phase of lcd_write_ctrl.
module lcd_write_ctrl_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= value_i;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/lcd_write_ctrl.sv
// HD44780 write controller: setup / EN pulse / hold / exec wait.
// Define LCD_WRITE_CTRL_INIT_EN for the built-in power-up init.
module lcd_write_ctrl
  import lcd_write_ctrl_pkg::*;
#(
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_CLEAR_CYC = 82000,
  parameter int T_PWRUP_CYC = 750000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [31:0] wr_data_i,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        lcd_blon_o,
  output logic        busy_o
);

  localparam int TS = (T_SETUP_CYC < 1) ? 1 : T_SETUP_CYC;
  localparam int TE = (T_EN_CYC    < 1) ? 1 : T_EN_CYC;
  localparam int TH = (T_HOLD_CYC  < 1) ? 1 : T_HOLD_CYC;
  localparam int TX = (T_EXEC_CYC  < 1) ? 1 : T_EXEC_CYC;
  localparam int TC = (T_CLEAR_CYC < 1) ? 1 : T_CLEAR_CYC;
  localparam int TP = (T_PWRUP_CYC < 1) ? 1 : T_PWRUP_CYC;

  localparam int M0 = (TS > TE) ? TS : TE;
  localparam int M1 = (M0 > TH) ? M0 : TH;
  localparam int M2 = (M1 > TX) ? M1 : TX;
  localparam int M3 = (M2 > TC) ? M2 : TC;
  localparam int TM = (M3 > TP) ? M3 : TP;
  localparam int CW = $clog2(TM) + 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(TS - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(TE - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(TH - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(TX - 1);
  localparam logic [CW-1:0] LD_CLEAR = CW'(TC - 1);
`ifdef LCD_WRITE_CTRL_INIT_EN
  localparam logic [CW-1:0] LD_PWRUP = CW'(TP - 1);
`endif

  state_e        state;
  logic          ld;
  logic [CW-1:0] ld_val;
  logic          zero;
  logic [20:0]   unused_bits;

`ifdef LCD_WRITE_CTRL_INIT_EN
  logic          armed;
  logic          in_init;
  logic [2:0]    idx;
`endif

  assign unused_bits = wr_data_i[29:9];
  assign wr_ready_o  = (state == ST_IDLE);
  assign busy_o      = ~wr_ready_o;
  assign lcd_rw_o    = 1'b0;

  // Timer reload on every state entry
  always_comb begin
    ld     = 1'b0;
    ld_val = '0;
    unique case (state)
      ST_IDLE: if (wr_valid_i) begin
        ld     = 1'b1;
        ld_val = LD_SETUP;
      end
      ST_SETUP: if (zero) begin
        ld     = 1'b1;
        ld_val = LD_EN;
      end
      ST_EN_HI: if (zero) begin
        ld     = 1'b1;
        ld_val = LD_HOLD;
      end
      ST_HOLD: if (zero) begin
        ld     = 1'b1;
        ld_val = is_long(lcd_rs_o, lcd_data_o)
               ? LD_CLEAR : LD_EXEC;
      end
`ifdef LCD_WRITE_CTRL_INIT_EN
      ST_PWRUP: if (!armed) begin
        ld     = 1'b1;
        ld_val = LD_PWRUP;
      end
      ST_INIT: if (idx != 3'(INIT_LEN)) begin
        ld     = 1'b1;
        ld_val = LD_SETUP;
      end
`endif
      default: ;
    endcase
  end

  lcd_write_ctrl_timer #(
    .W (CW)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (ld),
    .value_i (ld_val),
    .zero_o  (zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
`ifdef LCD_WRITE_CTRL_INIT_EN
      state   <= ST_PWRUP;
      armed   <= 1'b0;
      in_init <= 1'b1;
      idx     <= '0;
`else
      state   <= ST_IDLE;
`endif
      lcd_data_o <= '0;
      lcd_rs_o   <= 1'b0;
      lcd_en_o   <= 1'b0;
      lcd_on_o   <= 1'b0;
      lcd_blon_o <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (wr_valid_i) begin
          lcd_data_o <= wr_data_i[7:0];
          lcd_rs_o   <= wr_data_i[RS_BIT];
          lcd_on_o   <= wr_data_i[ON_BIT];
          lcd_blon_o <= wr_data_i[BLON_BIT];
          state      <= ST_SETUP;
        end
        ST_SETUP: if (zero) begin
          lcd_en_o <= 1'b1;
          state    <= ST_EN_HI;
        end
        ST_EN_HI: if (zero) begin
          lcd_en_o <= 1'b0;
          state    <= ST_HOLD;
        end
        ST_HOLD: if (zero) begin
          state <= ST_EXEC;
        end
        ST_EXEC: if (zero) begin
`ifdef LCD_WRITE_CTRL_INIT_EN
          state <= in_init ? ST_INIT : ST_IDLE;
`else
          state <= ST_IDLE;
`endif
        end
`ifdef LCD_WRITE_CTRL_INIT_EN
        ST_PWRUP: begin
          if (!armed) begin
            armed    <= 1'b1;
            lcd_on_o <= 1'b1;
          end else if (zero) begin
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (idx == 3'(INIT_LEN)) begin
            in_init <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            lcd_data_o <= init_cmd(idx);
            lcd_rs_o   <= 1'b0;
            idx        <= idx + 1'b1;
            state      <= ST_SETUP;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Directed bench for lcd_write_ctrl with shortened timings.
// Covers timing, clear/home waits, back-to-back, reset abort, init.
module tb_lcd_write_ctrl;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [31:0] wdata;
  logic [7:0]  data;
  logic        rs;
  logic        rw;
  logic        en;
  logic        on;
  logic        blon;
  logic        busy;

  int total = 0;
  int bad   = 0;

`ifdef LCD_WRITE_CTRL_INIT_EN
  localparam logic RST_RDY = 1'b0;
`else
  localparam logic RST_RDY = 1'b1;
`endif

  lcd_write_ctrl #(
    .T_SETUP_CYC (2),
    .T_EN_CYC    (4),
    .T_HOLD_CYC  (2),
    .T_EXEC_CYC  (10),
    .T_CLEAR_CYC (20),
    .T_PWRUP_CYC (30)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_valid_i (valid),
    .wr_ready_o (ready),
    .wr_data_i  (wdata),
    .lcd_data_o (data),
    .lcd_rs_o   (rs),
    .lcd_rw_o   (rw),
    .lcd_en_o   (en),
    .lcd_on_o   (on),
    .lcd_blon_o (blon),
    .busy_o     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transfer; k counts negedges after the accept edge
  task automatic xfer(
    input  logic [31:0] d,
    output int          lat,
    output int          en_first,
    output int          en_last,
    output int          en_cnt,
    output int          bus_bad,
    output logic        on1,
    output logic        blon1
  );
    lat = -1; en_first = 0; en_last = 0;
    en_cnt = 0; bus_bad = 0; on1 = 0; blon1 = 0;
    @(negedge clk);
    check("rdy_pre", {31'd0, ready}, 32'd1);
    valid = 1'b1;
    wdata = d;
    @(posedge clk);
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        valid = 1'b0;
        on1   = on;
        blon1 = blon;
      end
      if (en) begin
        en_cnt++;
        if (en_first == 0) en_first = k;
        en_last = k;
      end
      if (data !== d[7:0] || rs !== d[8]) bus_bad++;
      if (ready) lat = k - 1;
    end
  endtask

  task automatic xfer_chk(
    input string       tag,
    input logic [31:0] d,
    input int          exp_lat
  );
    int lat, ef, el, ec, bb;
    logic o1, b1;
    xfer(d, lat, ef, el, ec, bb, o1, b1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_en_first"}, ef, 3);
    check({tag, "_en_last"}, el, 6);
    check({tag, "_en_cnt"}, ec, 4);
    check({tag, "_bus"}, bb, 0);
    check({tag, "_on1"}, {31'd0, o1}, {31'd0, d[31]});
    check({tag, "_blon1"}, {31'd0, b1}, {31'd0, d[30]});
  endtask

  initial begin
    int   rdy_k, viol, n, prev;
    logic [7:0] d2;
    logic       r2;
    logic [7:0] cmds [6];
    logic [7:0] exp_cmds [6];

    exp_cmds = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    rst_n = 1'b0;
    valid = 1'b0;
    wdata = '0;

    #12;
    check("rst_ready", {31'd0, ready}, {31'd0, RST_RDY});
    check("rst_busy",  {31'd0, busy},  {31'd0, ~RST_RDY});
    check("rst_en",    {31'd0, en},    32'd0);
    check("rst_data",  {24'd0, data},  32'd0);
    check("rst_rs",    {31'd0, rs},    32'd0);
    check("rst_rw",    {31'd0, rw},    32'd0);
    check("rst_on",    {31'd0, on},    32'd0);
    check("rst_blon",  {31'd0, blon},  32'd0);

    @(negedge clk);
    rst_n = 1'b1;

`ifdef LCD_WRITE_CTRL_INIT_EN
    n = 0; prev = 0; rdy_k = -1; viol = 0;
    for (int k = 1; k <= 2000 && rdy_k < 0; k++) begin
      @(negedge clk);
      if (k == 3) begin
        check("init_on", {31'd0, on}, 32'd1);
        check("init_rdy", {31'd0, ready}, 32'd0);
      end
      if (en && prev == 0) begin
        if (n < 6) cmds[n] = data;
        if (rs !== 1'b0) viol++;
        n++;
      end
      if (blon !== 1'b0) viol++;
      prev = int'(en);
      if (ready) rdy_k = k;
    end
    check("init_done", {31'd0, ready}, 32'd1);
    check("init_pulses", n, 6);
    check("init_viol", viol, 0);
    for (int i = 0; i < 6; i++)
      check("init_cmd", {24'd0, cmds[i]}, {24'd0, exp_cmds[i]});
`endif

    xfer_chk("data41", 32'h0000_0141, 18);
    xfer_chk("clear",  32'h0000_0001, 28);
    xfer_chk("home",   32'h0000_0002, 28);
    xfer_chk("home3",  32'h0000_0003, 28);
    xfer_chk("rs_01",  32'h0000_0101, 18);
    xfer_chk("cmd04",  32'h0000_0004, 18);
    xfer_chk("onbl",   32'hC000_0080, 18);
    check("on_keep",   {31'd0, on},   32'd1);
    check("blon_keep", {31'd0, blon}, 32'd1);
    xfer_chk("ononly", 32'h8000_0041, 18);
    check("blon_off",  {31'd0, blon}, 32'd0);

    // back-to-back: valid held through busy
    @(negedge clk);
    valid = 1'b1;
    wdata = 32'h0000_0141;
    @(posedge clk);
    rdy_k = -1; viol = 0; d2 = '0; r2 = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) wdata = 32'h0000_0142;
      if (k >= 3 && k <= 8 && (data !== 8'h41 || rs !== 1'b1))
        viol++;
      if (rdy_k > 0 && k == rdy_k + 1) begin
        d2 = data;
        r2 = ready;
        valid = 1'b0;
        break;
      end
      if (ready && rdy_k < 0) rdy_k = k;
    end
    check("b2b_rdy_k", rdy_k, 19);
    check("b2b_viol", viol, 0);
    check("b2b_data2", {24'd0, d2}, 32'h42);
    check("b2b_busy2", {31'd0, r2}, 32'd0);
    rdy_k = -1;
    for (int k = 1; k <= 100 && rdy_k < 0; k++) begin
      @(negedge clk);
      if (ready) rdy_k = k;
    end
    check("b2b_lat2", rdy_k, 18);

    // reset during EN_HI
    @(negedge clk);
    valid = 1'b1;
    wdata = 32'hC000_0141;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_en_pre", {31'd0, en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_en",   {31'd0, en},   32'd0);
    check("abort_data", {24'd0, data}, 32'd0);
    check("abort_rs",   {31'd0, rs},   32'd0);
    check("abort_on",   {31'd0, on},   32'd0);
    check("abort_blon", {31'd0, blon}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifndef LCD_WRITE_CTRL_INIT_EN
    @(negedge clk);
    check("post_rdy",  {31'd0, ready}, 32'd1);
    check("post_busy", {31'd0, busy},  32'd0);
    xfer_chk("post", 32'h0000_0141, 18);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
